// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for one side of a pipeline register stage.
// The producer uses the master modport; the consumer uses the slave modport.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register stage with valid/ready back-pressure, optional skid entry and flush.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt / flush_cnt performance counter ports.
module pipe_stage_reg #(
  parameter int                 DATA_W      = 128,
  parameter int                 CTRL_W      = 8,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = {CTRL_W{1'b0}},
  parameter int                 SKID        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_stage_reg_if.slave       in_if,
  pipe_stage_reg_if.master      out_if
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                out_valid_r;
  logic [DATA_W-1:0]   main_data_r;
  logic [CTRL_W-1:0]   main_ctrl_r;
  logic [DATA_W-1:0]   skid_data_r;
  logic [CTRL_W-1:0]   skid_ctrl_r;
  logic                in_ready_s;
  logic                in_xfer_s;
  logic                out_xfer_s;
  logic                load_in_s;
  logic                load_skid_s;
  logic                pop_skid_s;

  assign in_xfer_s     = in_if.valid && in_ready_s;
  assign out_xfer_s    = out_valid_r && out_if.ready;
  assign in_if.ready   = in_ready_s;
  assign out_if.valid  = out_valid_r;
  assign out_if.data   = main_data_r;
  assign out_if.ctrl   = main_ctrl_r;

  // Next-state and entry-move decode; flush overrides every transfer.
  always_comb begin
    state_nxt_s = state_r;
    load_in_s   = 1'b0;
    load_skid_s = 1'b0;
    pop_skid_s  = 1'b0;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            state_nxt_s = ST_ONE;
            load_in_s   = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            state_nxt_s = ST_ONE;
            load_in_s   = 1'b1;
          end else if (in_xfer_s) begin
            // Only reachable with a skid entry: without one, in_ready implies out_ready here.
            state_nxt_s = ST_FULL;
            load_skid_s = 1'b1;
          end else if (out_xfer_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_xfer_s) begin
            state_nxt_s = ST_ONE;
            pop_skid_s  = 1'b1;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State register and registered out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s != ST_EMPTY);
    end
  end

  // Entry storage; control falls back to the bubble value whenever an entry empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data_r <= {DATA_W{1'b0}};
      main_ctrl_r <= BUBBLE_CTRL;
      skid_data_r <= {DATA_W{1'b0}};
      skid_ctrl_r <= BUBBLE_CTRL;
    end else begin
      if (load_in_s) begin
        main_data_r <= in_if.data;
        main_ctrl_r <= in_if.ctrl;
      end else if (pop_skid_s) begin
        main_data_r <= skid_data_r;
        main_ctrl_r <= skid_ctrl_r;
      end else if (state_nxt_s == ST_EMPTY) begin
        main_ctrl_r <= BUBBLE_CTRL;
      end
      if (load_skid_s) begin
        skid_data_r <= in_if.data;
        skid_ctrl_r <= in_if.ctrl;
      end else if (state_nxt_s != ST_FULL) begin
        skid_ctrl_r <= BUBBLE_CTRL;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_ready
      logic in_ready_r;
      // Registered in_ready: low exactly while the stage will be full.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          in_ready_r <= 1'b1;
        end else begin
          in_ready_r <= (state_nxt_s != ST_FULL);
        end
      end
      assign in_ready_s = in_ready_r;
    end else begin : g_ready
      assign in_ready_s = (state_r == ST_EMPTY) || out_if.ready;
    end
  endgenerate

`ifdef PIPE_STAGE_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  // Saturating stall and effective-flush counters; flush itself never clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (out_valid_r && !out_if.ready) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (flush && (state_r != ST_EMPTY)) begin
        flush_cnt <= sat_inc(flush_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (skid and no-skid builds side by side).
module tb_pipe_stage_reg;
  logic clk;
  logic rst;
  logic flush;
  int   vec_cnt;
  int   err_cnt;

  pipe_stage_reg_if #(.DATA_W(128), .CTRL_W(8)) in_if ();
  pipe_stage_reg_if #(.DATA_W(128), .CTRL_W(8)) out_if ();
  pipe_stage_reg_if #(.DATA_W(128), .CTRL_W(8)) n_in_if ();
  pipe_stage_reg_if #(.DATA_W(128), .CTRL_W(8)) n_out_if ();

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, n_stall_cnt, n_flush_cnt;
`endif

  pipe_stage_reg #(.DATA_W(128), .CTRL_W(8), .BUBBLE_CTRL(8'h00), .SKID(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_if(in_if), .out_if(out_if)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipe_stage_reg #(.DATA_W(128), .CTRL_W(8), .BUBBLE_CTRL(8'h00), .SKID(0)) dut_noskid (
    .clk(clk), .rst(rst), .flush(flush), .in_if(n_in_if), .out_if(n_out_if)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] d, input logic [7:0] c);
    in_if.valid = v;
    in_if.data  = d;
    in_if.ctrl  = c;
  endtask

  task automatic test_reset();
    #3;
    vec_cnt++; if (out_if.valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got %0b want 0", out_if.valid); end
    vec_cnt++; if (out_if.data !== 128'h0) begin err_cnt++; $display("FAIL reset_data got %0h want 0", out_if.data); end
    vec_cnt++; if (out_if.ctrl !== 8'h00) begin err_cnt++; $display("FAIL reset_ctrl got %0h want 00", out_if.ctrl); end
    vec_cnt++; if (in_if.ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready got %0b want 1", in_if.ready); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    logic [127:0] exp_d;
    out_if.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 128'(i), 8'(i + 16));
      tick();
      exp_d = 128'(i);
      vec_cnt++; if (out_if.valid !== 1'b1 || out_if.data !== exp_d || out_if.ctrl !== 8'(i + 16)) begin
        err_cnt++; $display("FAIL stream_%0d got v=%0b d=%0h c=%0h want v=1 d=%0h c=%0h", i, out_if.valid, out_if.data, out_if.ctrl, exp_d, 8'(i + 16)); end
      vec_cnt++; if (in_if.ready !== 1'b1) begin err_cnt++; $display("FAIL stream_ready_%0d got %0b want 1", i, in_if.ready); end
    end
    drive(1'b0, 128'h0, 8'h00);
    tick();
    vec_cnt++; if (out_if.valid !== 1'b0) begin err_cnt++; $display("FAIL stream_end got %0b want 0", out_if.valid); end
  endtask

  task automatic test_backpressure();
    out_if.ready = 1'b0;
    drive(1'b1, 128'hA, 8'h0A);
    tick();
    vec_cnt++; if (out_if.data !== 128'hA || in_if.ready !== 1'b1) begin err_cnt++; $display("FAIL bp_first got d=%0h r=%0b want d=a r=1", out_if.data, in_if.ready); end
    drive(1'b1, 128'hB, 8'h0B);
    tick();
    vec_cnt++; if (out_if.data !== 128'hA || out_if.ctrl !== 8'h0A || in_if.ready !== 1'b0) begin err_cnt++; $display("FAIL bp_full got d=%0h c=%0h r=%0b want d=a c=0a r=0", out_if.data, out_if.ctrl, in_if.ready); end
    drive(1'b1, 128'hC, 8'h0C);
    tick();
    vec_cnt++; if (out_if.data !== 128'hA || in_if.ready !== 1'b0) begin err_cnt++; $display("FAIL bp_hold got d=%0h r=%0b want d=a r=0", out_if.data, in_if.ready); end
    out_if.ready = 1'b1;
    tick();
    vec_cnt++; if (out_if.valid !== 1'b1 || out_if.data !== 128'hB || out_if.ctrl !== 8'h0B || in_if.ready !== 1'b1) begin
      err_cnt++; $display("FAIL bp_second got v=%0b d=%0h c=%0h r=%0b want v=1 d=b c=0b r=1", out_if.valid, out_if.data, out_if.ctrl, in_if.ready); end
    tick();
    vec_cnt++; if (out_if.valid !== 1'b1 || out_if.data !== 128'hC) begin err_cnt++; $display("FAIL bp_third got v=%0b d=%0h want v=1 d=c", out_if.valid, out_if.data); end
    drive(1'b0, 128'h0, 8'h00);
    tick();
    vec_cnt++; if (out_if.valid !== 1'b0) begin err_cnt++; $display("FAIL bp_nodup got %0b want 0", out_if.valid); end
  endtask

  task automatic test_flush();
    out_if.ready = 1'b0;
    drive(1'b1, 128'h11, 8'h11);
    tick();
    drive(1'b1, 128'h22, 8'h22);
    tick();
    flush = 1'b1;
    drive(1'b1, 128'hDD, 8'hFF);
    tick();
    flush = 1'b0;
    vec_cnt++; if (out_if.valid !== 1'b0 || out_if.ctrl !== 8'h00 || in_if.ready !== 1'b1) begin
      err_cnt++; $display("FAIL flush_full got v=%0b c=%0h r=%0b want v=0 c=00 r=1", out_if.valid, out_if.ctrl, in_if.ready); end
    drive(1'b0, 128'h0, 8'h00);
    out_if.ready = 1'b1;
    tick();
    vec_cnt++; if (out_if.valid !== 1'b0 || out_if.ctrl !== 8'h00) begin err_cnt++; $display("FAIL flush_discard got v=%0b c=%0h want v=0 c=00", out_if.valid, out_if.ctrl); end
  endtask

  task automatic test_drain();
    out_if.ready = 1'b1;
    drive(1'b1, 128'hE, 8'hFF);
    tick();
    vec_cnt++; if (out_if.valid !== 1'b1 || out_if.ctrl !== 8'hFF) begin err_cnt++; $display("FAIL drain_load got v=%0b c=%0h want v=1 c=ff", out_if.valid, out_if.ctrl); end
    drive(1'b0, 128'h0, 8'h00);
    tick();
    vec_cnt++; if (out_if.valid !== 1'b0 || out_if.ctrl !== 8'h00) begin err_cnt++; $display("FAIL drain_bubble got v=%0b c=%0h want v=0 c=00", out_if.valid, out_if.ctrl); end
  endtask

  task automatic test_async_reset();
    out_if.ready = 1'b0;
    drive(1'b1, 128'h55, 8'h55);
    tick();
    drive(1'b1, 128'h66, 8'h66);
    tick();
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++; if (out_if.valid !== 1'b0 || out_if.data !== 128'h0 || out_if.ctrl !== 8'h00 || in_if.ready !== 1'b1) begin
      err_cnt++; $display("FAIL async_rst got v=%0b d=%0h c=%0h r=%0b want v=0 d=0 c=00 r=1", out_if.valid, out_if.data, out_if.ctrl, in_if.ready); end
    drive(1'b0, 128'h0, 8'h00);
    tick();
    rst = 1'b0;
    out_if.ready = 1'b1;
    drive(1'b1, 128'h77, 8'h07);
    tick();
    vec_cnt++; if (out_if.valid !== 1'b1 || out_if.data !== 128'h77) begin err_cnt++; $display("FAIL rst_first got v=%0b d=%0h want v=1 d=77", out_if.valid, out_if.data); end
    drive(1'b0, 128'h0, 8'h00);
    tick();
    vec_cnt++; if (out_if.valid !== 1'b0) begin err_cnt++; $display("FAIL rst_stale got %0b want 0", out_if.valid); end
  endtask

  task automatic test_noskid();
    n_out_if.ready = 1'b0;
    n_in_if.valid  = 1'b1;
    n_in_if.data   = 128'h1;
    n_in_if.ctrl   = 8'h81;
    #1;
    vec_cnt++; if (n_in_if.ready !== 1'b1) begin err_cnt++; $display("FAIL noskid_empty_ready got %0b want 1", n_in_if.ready); end
    tick();
    vec_cnt++; if (n_out_if.valid !== 1'b1 || n_out_if.data !== 128'h1 || n_in_if.ready !== 1'b0) begin
      err_cnt++; $display("FAIL noskid_load got v=%0b d=%0h r=%0b want v=1 d=1 r=0", n_out_if.valid, n_out_if.data, n_in_if.ready); end
    n_in_if.data = 128'h2;
    n_in_if.ctrl = 8'h82;
    tick();
    vec_cnt++; if (n_out_if.data !== 128'h1 || n_out_if.ctrl !== 8'h81) begin err_cnt++; $display("FAIL noskid_hold got d=%0h c=%0h want d=1 c=81", n_out_if.data, n_out_if.ctrl); end
    n_out_if.ready = 1'b1;
    #1;
    vec_cnt++; if (n_in_if.ready !== 1'b1) begin err_cnt++; $display("FAIL noskid_comb_ready got %0b want 1", n_in_if.ready); end
    tick();
    vec_cnt++; if (n_out_if.valid !== 1'b1 || n_out_if.data !== 128'h2) begin err_cnt++; $display("FAIL noskid_next got v=%0b d=%0h want v=1 d=2", n_out_if.valid, n_out_if.data); end
    n_in_if.valid = 1'b0;
    tick();
    vec_cnt++; if (n_out_if.valid !== 1'b0 || n_out_if.ctrl !== 8'h00) begin err_cnt++; $display("FAIL noskid_drain got v=%0b c=%0h want v=0 c=00", n_out_if.valid, n_out_if.ctrl); end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_if.ready = 1'b0;
    drive(1'b1, 128'hF, 8'h0F);
    tick();
    drive(1'b0, 128'h0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    vec_cnt++; if (stall_cnt !== 32'd5) begin err_cnt++; $display("FAIL perf_stall got %0d want 5", stall_cnt); end
    flush = 1'b1;
    out_if.ready = 1'b1;
    tick();
    flush = 1'b0;
    vec_cnt++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd5) begin err_cnt++; $display("FAIL perf_flush got f=%0d s=%0d want f=1 s=5", flush_cnt, stall_cnt); end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vec_cnt++; if (flush_cnt !== 32'd1) begin err_cnt++; $display("FAIL perf_empty_flush got %0d want 1", flush_cnt); end
  endtask
`endif

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst     = 1'b1;
    flush   = 1'b0;
    drive(1'b0, 128'h0, 8'h00);
    out_if.ready   = 1'b0;
    n_in_if.valid  = 1'b0;
    n_in_if.data   = 128'h0;
    n_in_if.ctrl   = 8'h00;
    n_out_if.ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_drain();
    test_async_reset();
    test_noskid();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
